// File: rtl/spu_pipe_pkg.sv
// spu_pipe_pkg: shared stall-controller state encoding, pipeline NOP encodings and counter sizing helper
package spu_pipe_pkg;
  typedef enum logic [1:0] {HOLD, RUN, LONG, FLUSH} stall_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [15:0] NOP_CTRL = 16'h0000;
  function automatic int cnt_width(input int rh, input int fd, input int lw);
    int w;
    w = lw;
    if ($clog2(rh) > w) w = $clog2(rh);
    if ($clog2(fd) > w) w = $clog2(fd);
    return (w > 0) ? w : 1;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter, sync clear (clk, clear, en -> count), holds at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = clear ? '0 : (en && !(&count_q)) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk) count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard requests (Stall_Req, Flush_Req, LongOp_Start/Lat) -> PC/IFID/IDEX enables, Busy, saturating Stall_Cnt
module pipe_stall_ctrl
  import spu_pipe_pkg::*;
#(
  parameter int RESET_HOLD  = 4,
  parameter int FLUSH_DEPTH = 1,
  parameter int LAT_W       = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Stall_Req,
  input  logic             Flush_Req,
  input  logic             LongOp_Start,
  input  logic [LAT_W-1:0] LongOp_Lat,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             Busy,
  output logic [CNT_W-1:0] Stall_Cnt
);
  localparam int CW = cnt_width(RESET_HOLD, FLUSH_DEPTH, LAT_W);
  stall_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hold, flush_o, stall_o, last;
  always_comb begin
    hold        = state_q == HOLD;
    flush_o     = state_q == FLUSH || (!hold && Flush_Req);
    stall_o     = !flush_o && (state_q == LONG || (state_q == RUN && Stall_Req));
    PC_Write    = !hold && !stall_o;
    IFID_Write  = !hold && !stall_o;
    IFID_Flush  = hold || flush_o;
    IDEX_Bubble = hold || flush_o || stall_o;
    Busy        = state_q != RUN;
    last        = cnt_q == '0;
    state_d     = state_q;
    cnt_d       = cnt_q - 1'b1;
    if (hold)
      state_d = last ? RUN : HOLD;
    else if (Flush_Req) begin
      state_d = (FLUSH_DEPTH > 1) ? FLUSH : RUN;
      cnt_d   = CW'(FLUSH_DEPTH - 2);
    end else if (state_q == RUN) begin
      if (LongOp_Start && |LongOp_Lat) begin
        state_d = LONG;
        cnt_d   = CW'(LongOp_Lat - 1'b1);
      end
    end else if (last)
      state_d = RUN;
    if (!Reset) begin
      state_d = HOLD;
      cnt_d   = CW'(RESET_HOLD - 1);
    end
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .clear(!Reset),
    .en   (!PC_Write && !hold),
    .count(Stall_Cnt)
  );
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: random + directed check of two pipe_stall_ctrl configs against a cycles-remaining model
module tb_pipe_stall_ctrl;
  logic clk = 0, reset_n = 0, stall = 0, flush = 0, lo = 0;
  logic [3:0] lat = 0;
  logic [1:0] pw, ifw, ifl, bub, busy;
  logic [15:0] sc_a;
  logic [3:0] sc_b;
  int vectors = 0, miscompares = 0;
  int hold_l[2], long_l[2], flush_l[2], scm[2];
  int fd[2] = '{1, 3};
  int cmax[2] = '{65535, 15};
  bit mvalid = 0;
  always #5 clk = ~clk;
  pipe_stall_ctrl u_a (
    .clk(clk), .Reset(reset_n), .Stall_Req(stall), .Flush_Req(flush), .LongOp_Start(lo),
    .LongOp_Lat(lat), .PC_Write(pw[0]), .IFID_Write(ifw[0]), .IFID_Flush(ifl[0]),
    .IDEX_Bubble(bub[0]), .Busy(busy[0]), .Stall_Cnt(sc_a)
  );
  pipe_stall_ctrl #(.FLUSH_DEPTH(3), .CNT_W(4)) u_b (
    .clk(clk), .Reset(reset_n), .Stall_Req(stall), .Flush_Req(flush), .LongOp_Start(lo),
    .LongOp_Lat(lat), .PC_Write(pw[1]), .IFID_Write(ifw[1]), .IFID_Flush(ifl[1]),
    .IDEX_Bubble(bub[1]), .Busy(busy[1]), .Stall_Cnt(sc_b)
  );
  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  // Model: counts of cycles remaining in the post-reset hold, a long freeze and a flush burst.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [4:0] e, a;
      int sc_act;
      logic bz;
      bz = long_l[k] > 0 || flush_l[k] > 0;
      if (hold_l[k] > 0) e = 5'b00111;
      else if (flush_l[k] > 0 || flush) e = {4'b1111, bz};
      else if (long_l[k] > 0 || stall) e = {4'b0001, bz};
      else e = {4'b1100, bz};
      a = {pw[k], ifw[k], ifl[k], bub[k], busy[k]};
      sc_act = (k == 0) ? int'(sc_a) : int'(sc_b);
      if (mvalid) begin
        check($sformatf("outs%0d{pw,ifw,ifl,bub,busy}", k), int'(a), int'(e));
        check($sformatf("stall_cnt%0d", k), sc_act, scm[k]);
      end
      if (!reset_n) begin
        hold_l[k] = 4; long_l[k] = 0; flush_l[k] = 0; scm[k] = 0;
      end else if (hold_l[k] > 0) hold_l[k]--;
      else begin
        if (!e[4] && scm[k] < cmax[k]) scm[k]++;
        if (flush) begin flush_l[k] = fd[k] - 1; long_l[k] = 0; end
        else if (flush_l[k] > 0) flush_l[k]--;
        else if (long_l[k] > 0) long_l[k]--;
        else if (lo) long_l[k] = int'(lat);
      end
    end
    if (!reset_n) mvalid = 1;
  end
  task automatic cyc(input logic r, input logic s, input logic f, input logic l, input int lt);
    reset_n = r; stall = s; flush = f; lo = l; lat = 4'(lt);
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
  endtask
  int n;
  initial begin
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    n = 0;
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n += int'(!pw[0]);
      if (i == 0) check("hold_stall_cnt", int'(sc_a), 0);
      @(posedge clk); #1;
    end
    check("hold_cycles", n, 4);
    @(negedge clk); check("run_after_hold", int'(pw[0]), 1);
    @(posedge clk); #1;
    reset_n = 1; stall = 1;
    @(negedge clk);
    check("stall_pw_ifw_bub", int'({pw[0], ifw[0], bub[0]}), 1);
    @(posedge clk); #1;
    stall = 0;
    @(negedge clk); check("stall_cnt_1", int'(sc_a), 1);
    @(posedge clk); #1;
    lo = 1; lat = 3;
    @(negedge clk); check("long_issue_pw", int'(pw[0]), 1);
    @(posedge clk); #1;
    lo = 0; lat = 0; n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); n += int'(!pw[0]); @(posedge clk); #1;
    end
    check("long_frozen", n, 3);
    @(negedge clk);
    check("long_done_pw", int'(pw[0]), 1);
    check("long_stall_cnt", int'(sc_a), 4);
    @(posedge clk); #1;
    cyc(1, 0, 0, 1, 5);
    cyc(1, 0, 0, 0, 0);
    flush = 1;
    @(negedge clk); check("long_abort_flush", int'({pw[0], ifl[0]}), 3);
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk); check("after_abort", int'({pw[0], busy[0]}), 2);
    @(posedge clk); #1;
    idle(4);
    flush = 1; stall = 1; lo = 1; lat = 7; n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n += int'(ifl[1]);
      if (!pw[1]) check("fd3_pw", 0, 1);
      @(posedge clk); #1;
      flush = 0; stall = 0; lo = 0; lat = 0;
    end
    check("fd3_flush_cycles", n, 3);
    @(negedge clk); check("fd3_no_long", int'(busy[1]), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      cyc(($urandom_range(0, 299) != 0), r < 25, $urandom_range(0, 99) < 8,
          $urandom_range(0, 99) < 12, $urandom_range(0, 15));
    end
    cyc(0, 0, 0, 0, 0);
    idle(5);
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 0);
    reset_n = 1; stall = 0;
    @(negedge clk); check("sat_15", int'(sc_b), 15);
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    check("reset_clear_cnt", int'(sc_b), 0);
    check("reset_busy_hold", int'({busy[1], pw[1]}), 2);
    @(posedge clk); #1;
    idle(6);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
